// File: rtl/snoop_cache_if.sv
// rtl/snoop_cache_if.sv - CPU request port and coherence bus bundle for snoop_cache_controller
//
// Purpose: groups the CPU handshake and the 13-bit coherence bus of one cache.
// Signals:
//   execute_instruction  request strobe, sampled only while the cache is idle
//   instruction          0 = read, 1 = write
//   address[2:0]         word address
//   data_in[3:0]         write data
//   data_out[3:0]        read result, held until the next read completes
//   done                 one-cycle completion pulse
//   bus_in[12:0]         arbiter -> cache (reply or peer broadcast)
//   bus_out[12:0]        cache -> arbiter
// Message bits: [12] write-back, [11] supply, [10] broadcast, [9] read miss/reply,
//               [8] write miss/invalidate, [7] reserved 0, [6:4] address, [3:0] data
// Modports: master = CPU/arbiter side, slave = cache controller.
interface snoop_cache_if;
  logic        execute_instruction;
  logic        instruction;
  logic [2:0]  address;
  logic [3:0]  data_in;
  logic [3:0]  data_out;
  logic        done;
  logic [12:0] bus_in;
  logic [12:0] bus_out;

  modport master (
    output execute_instruction, instruction, address, data_in, bus_in,
    input  data_out, done, bus_out
  );

  modport slave (
    input  execute_instruction, instruction, address, data_in, bus_in,
    output data_out, done, bus_out
  );
endinterface

// File: rtl/snoop_cache_controller.sv
// rtl/snoop_cache_controller.sv - per-CPU direct-mapped MSI snooping cache controller
//
// Purpose: serves CPU reads/writes from a 2^INDEX_BITS-line direct-mapped cache
// (one 4-bit word per line, states I/S/M), issues write-back, miss and invalidate
// messages on the coherence bus and snoops peer broadcasts.
// Ports:
//   clock  system clock, all state updates on posedge
//   reset  synchronous active-high reset
//   cpu    snoop_cache_if.slave: CPU request/response and bus_in/bus_out
// Parameters:
//   INDEX_BITS  cache index width (1..2); tag = address[2:INDEX_BITS]
module snoop_cache_controller #(
  parameter int INDEX_BITS = 2
) (
  input  logic          clock,
  input  logic          reset,
  snoop_cache_if.slave  cpu
);

  localparam int TAG_BITS  = 3 - INDEX_BITS;
  localparam int NUM_LINES = 1 << INDEX_BITS;

  typedef enum logic [1:0] {
    ST_I = 2'b00,
    ST_S = 2'b01,
    ST_M = 2'b10
  } line_state_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    INV,
    WB,
    MISS,
    FILL,
    DONE
  } fsm_t;

  function automatic logic [12:0] msg(input logic wb, input logic sup, input logic bc,
                                      input logic rd, input logic wr,
                                      input logic [2:0] a, input logic [3:0] d);
    return {wb, sup, bc, rd, wr, 1'b0, a, d};
  endfunction

  // Cache array
  line_state_t         line_st   [NUM_LINES];
  logic [TAG_BITS-1:0] line_tag  [NUM_LINES];
  logic [3:0]          line_data [NUM_LINES];

  // Latched request
  fsm_t                  state, next_state;
  logic                  req_write;
  logic [2:0]            req_addr;
  logic [3:0]            req_data;
  logic [3:0]            fill_data;
  logic [INDEX_BITS-1:0] req_idx;
  logic [TAG_BITS-1:0]   req_tag;

  // Snoop pipeline: bus_in is registered, evaluated the following cycle
  logic                  snp_bc, snp_rd, snp_wr;
  logic [2:0]            snp_addr;
  logic [INDEX_BITS-1:0] snp_idx;
  logic [TAG_BITS-1:0]   snp_tag;
  logic                  snp_hit, snp_rd_m, snp_inv, snp_inv_m;
  logic [1:0]            snp_cnt;
  logic [12:0]           snp_msg;
  logic                  bus_busy;

  // Outputs
  logic       done_q;
  logic [3:0] data_out_q;

  // FSM control towards the datapath
  logic [12:0]         fsm_bus;
  logic [12:0]         miss_msg;
  logic                line_we;
  line_state_t         we_state;
  logic [TAG_BITS-1:0] we_tag;
  logic [3:0]          we_data;
  logic                load_dout;
  logic [3:0]          dout_val;
  logic                req_hit;
  logic                reply;

  assign req_idx  = req_addr[INDEX_BITS-1:0];
  assign req_tag  = req_addr[2:INDEX_BITS];
  assign req_hit  = (line_st[req_idx] != ST_I) && (line_tag[req_idx] == req_tag);
  assign reply    = cpu.bus_in[9] && !cpu.bus_in[10] && (cpu.bus_in[6:4] == req_addr);
  assign miss_msg = msg(1'b0, 1'b0, 1'b1, !req_write, req_write, req_addr, 4'h0);

  assign snp_idx   = snp_addr[INDEX_BITS-1:0];
  assign snp_tag   = snp_addr[2:INDEX_BITS];
  assign snp_hit   = snp_bc && (line_st[snp_idx] != ST_I) && (line_tag[snp_idx] == snp_tag);
  assign snp_rd_m  = snp_hit && snp_rd && (line_st[snp_idx] == ST_M);
  assign snp_inv   = snp_hit && !snp_rd && snp_wr;
  assign snp_inv_m = snp_inv && (line_st[snp_idx] == ST_M);

  // A snoop response owns the bus; the FSM's own message is suppressed meanwhile.
  assign bus_busy     = (snp_cnt != 2'd0);
  assign cpu.bus_out  = bus_busy ? snp_msg : fsm_bus;
  assign cpu.done     = done_q;
  assign cpu.data_out = data_out_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    fsm_bus    = '0;
    line_we    = 1'b0;
    we_state   = ST_I;
    we_tag     = req_tag;
    we_data    = req_data;
    load_dout  = 1'b0;
    dout_val   = line_data[req_idx];
    case (state)
      IDLE: begin
        if (cpu.execute_instruction) next_state = LOOKUP;
      end
      LOOKUP: begin
        if (req_hit) begin
          if (!req_write) begin
            load_dout  = 1'b1;
            next_state = DONE;
          end else if (line_st[req_idx] == ST_M) begin
            line_we    = 1'b1;
            we_state   = ST_M;
            next_state = DONE;
          end else begin
            next_state = INV;
          end
        end else if (line_st[req_idx] == ST_M) begin
          next_state = WB;
        end else begin
          next_state = MISS;
        end
      end
      INV: begin
        fsm_bus = msg(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, req_addr, 4'h0);
        if (!bus_busy) begin
          line_we    = 1'b1;
          we_state   = ST_M;
          next_state = DONE;
        end
      end
      WB: begin
        fsm_bus = msg(1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                      {line_tag[req_idx], req_idx}, line_data[req_idx]);
        if (!bus_busy) begin
          // Drop the victim but keep its tag/data untouched
          line_we    = 1'b1;
          we_state   = ST_I;
          we_tag     = line_tag[req_idx];
          we_data    = line_data[req_idx];
          next_state = MISS;
        end
      end
      MISS: begin
        fsm_bus = miss_msg;
        // The reply is accepted even while a snoop response holds the bus,
        // so a pending miss can never be lost.
        if (reply) next_state = FILL;
      end
      FILL: begin
        // The request stays on the bus until the fill edge
        fsm_bus    = miss_msg;
        line_we    = 1'b1;
        we_state   = req_write ? ST_M : ST_S;
        we_data    = req_write ? req_data : fill_data;
        load_dout  = !req_write;
        dout_val   = fill_data;
        next_state = DONE;
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_LINES; i++) begin
        line_st[i]   <= ST_I;
        line_tag[i]  <= '0;
        line_data[i] <= '0;
      end
      req_write  <= 1'b0;
      req_addr   <= '0;
      req_data   <= '0;
      fill_data  <= '0;
      snp_bc     <= 1'b0;
      snp_rd     <= 1'b0;
      snp_wr     <= 1'b0;
      snp_addr   <= '0;
      snp_cnt    <= '0;
      snp_msg    <= '0;
      done_q     <= 1'b0;
      data_out_q <= '0;
    end else begin
      snp_bc   <= cpu.bus_in[10];
      snp_rd   <= cpu.bus_in[9];
      snp_wr   <= cpu.bus_in[8];
      snp_addr <= cpu.bus_in[6:4];
      done_q   <= (state == DONE);

      if (state == IDLE && cpu.execute_instruction) begin
        req_write <= cpu.instruction;
        req_addr  <= cpu.address;
        req_data  <= cpu.data_in;
      end

      if (state == MISS && reply) fill_data <= cpu.bus_in[3:0];

      if (load_dout) data_out_q <= dout_val;

      // Snoop actions: a peer read of a dirty line is supplied for two cycles
      // and the line downgrades; a peer write/invalidate drops the line, with a
      // one-cycle write-back if it was dirty.
      if (snp_rd_m) begin
        line_st[snp_idx] <= ST_S;
        snp_msg <= msg(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, snp_addr, line_data[snp_idx]);
        snp_cnt <= 2'd2;
      end else if (snp_inv_m) begin
        line_st[snp_idx] <= ST_I;
        snp_msg <= msg(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, snp_addr, line_data[snp_idx]);
        snp_cnt <= 2'd1;
      end else begin
        if (snp_inv) line_st[snp_idx] <= ST_I;
        if (snp_cnt != 2'd0) snp_cnt <= snp_cnt - 2'd1;
      end

      // The FSM's own line write comes last so it overrides a same-edge snoop update
      if (line_we) begin
        line_st[req_idx]   <= we_state;
        line_tag[req_idx]  <= we_tag;
        line_data[req_idx] <= we_data;
      end
    end
  end

endmodule

// File: doc/snoop_cache_controller.md
# snoop_cache_controller

Per-CPU snooping cache controller for the two-CPU shared-memory system. It serves the CPU's read and write requests from a small direct-mapped MSI cache. It issues write-back, read-miss, write-miss and invalidate messages on the 13-bit coherence bus and snoops the peer's broadcasts to supply, downgrade or invalidate lines. It sits between the CPU request port and the bus arbiter/memory, one instance per CPU.

## Interface
- INDEX_BITS, 2, cache index width; 2^INDEX_BITS lines, each holding tag = address[2:INDEX_BITS], one 4-bit data word and a 2-bit state (I=00, S=01, M=10).
- clock  in  1  system clock; all state updates on posedge
- reset  in  1  synchronous, active-high; sampled on posedge clock
- execute_instruction  in  1  request strobe, sampled only in IDLE
- instruction  in  1  0 = read, 1 = write
- address  in  3  word address
- data_in  in  4  write data
- data_out  out  4  read result
- done  out  1  one-cycle completion pulse
- bus_in  in  13  message from arbiter (reply or peer broadcast)
- bus_out  out  13  message to arbiter

Message fields (both directions):
- [12] write-back
- [11] supply (cache provides data, memory aborted)
- [10] broadcast to peer
- [9] read miss / reply
- [8] write miss / invalidate
- [7] reserved, driven 0
- [6:4] address
- [3:0] data

## Operation
- Reset: all lines I with tag 0 and data 0; state IDLE; bus_out = 0, done = 0, data_out = 0.
- IDLE: on execute_instruction = 1, latch instruction, address and data_in, then go to LOOKUP. Requests arriving while busy are ignored.
- LOOKUP, hit (state S or M with tag match):
  - Read: data_out <= line data, go to DONE.
  - Write to an M line: line data <= latched data, go to DONE.
  - Write to an S line: go to INV.
- LOOKUP, miss: if the victim line is M, go to WB; otherwise go to MISS.
- INV: drive bus_out [10]=1, [8]=1, [6:4]=addr, [3:0]=0 for one cycle. Line <= M with the new data, then go to DONE.
- WB: drive bus_out [12]=1, [6:4]={victim tag, index}, [3:0]=victim data for one cycle. Victim <= I, then go to MISS.
- MISS: hold bus_out [10]=1, [6:4]=addr, with [9]=1 for a read or [8]=1 for a write, until a reply is sampled.
  - A reply is bus_in[9]=1 and bus_in[10]=0 and bus_in[6:4]=addr.
  - When the reply is sampled, go to FILL.
- FILL:
  - Read: line <= S with the reply data; data_out <= reply data.
  - Write: line <= M with the latched data_in.
  - Then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- data_out holds its value until the next read completes.
- bus_out is 0 in every cycle not listed above.
- Snoop, evaluated every cycle on bus_in[10]=1 whose address matches a valid line (tag and index):
  - [9] read miss, line M: drive bus_out [12]=1, [11]=1, addr and data for two consecutive cycles; line <= S.
  - [9] read miss, line S: no action.
  - [8] write miss/invalidate, line M: drive [12]=1 with addr and data for one cycle; line <= I.
  - [8] write miss/invalidate, line S: line <= I, no bus output.
- Snoop priority: a snoop response owns bus_out. If the FSM would drive INV, WB or MISS in the same cycle, it stalls in place until bus_out is free. Cache array updates from the snoop take effect before the FSM's own update in the same edge.
- Snoop hitting the line the FSM is filling: the snoop acts on the pre-fill state, and FILL then overwrites. A pending own miss is never cancelled.
- Reset mid-operation: returns to IDLE and invalidates all lines. No pending bus message is completed.

## Timing
- Request sampled at edge N.
- Read hit: data_out and done valid after edge N+2.
- Write hit on M: done valid after edge N+2.
- Write hit on S: invalidate on bus_out during cycle N+1..N+2; done after edge N+3.
- Clean miss: MISS output starts after edge N+1.
- Dirty miss: WB during cycle N+1..N+2; MISS output starts after edge N+2.
- Reply sampled at edge R: bus_out drops and the array is written at edge R+1; done after edge R+2.
- Snoop sampled at edge S: response appears on bus_out after edge S+1. Line state changes at edge S+1.

## Test plan
- Reset, then read addr 5: MISS drives bus_out 0x4_00|0x250 ([10],[9],addr 5). Reply bus_in [9]=1, addr 5, data 0xA: data_out=0xA, done pulses 2 cycles after the reply, line 1 = S.
- Write addr 5, data 0x3 (line S): one-cycle invalidate [10],[8],addr 5. Line becomes M with data 3; done 3 cycles after the request.
- With addr 5 in M, read addr 1 (same index): WB of addr 5, data 3, then read miss addr 1. Reply data 0x7 gives data_out=7.
- With addr 5 in M, inject a snoop read miss on addr 5: two cycles of [12],[11], addr 5, data 3. Line becomes S.
- With addr 5 in S, inject a snoop invalidate on addr 5: no bus output; a following read of addr 5 misses.
- Assert reset while in MISS: bus_out=0, done=0 next cycle; all lines I; execute_instruction ignored until IDLE.
